// File: rtl/logic32_pkg.sv
// Shared opcodes, default width and opcode decode for the 32-bit logic unit.
// Optional XOR support is enabled by defining LOGIC32_XOR_EN.
package logic32_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [7:0] OP_AND32 = 8'h02;
    localparam logic [7:0] OP_OR32  = 8'h03;
    localparam logic [7:0] OP_XOR32 = 8'h04;
    localparam logic [7:0] OP_NOR32 = 8'h05;

    // True for every opcode this unit executes; XOR is only legal when the feature is built in.
    function automatic logic is_logic_op(input logic [7:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_AND32: legal = 1'b1;
            OP_OR32:  legal = 1'b1;
            OP_NOR32: legal = 1'b1;
`ifdef LOGIC32_XOR_EN
            OP_XOR32: legal = 1'b1;
`endif
            default:  legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/logic32_if.sv
// Operand/opcode request and registered result bus of the logic unit.
// Signal set is independent of LOGIC32_XOR_EN.
interface logic32_if
    import logic32_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic [7:0]       alu_op;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal_op;

    modport master (
        output in_valid, alu_op, in1, in2,
        input  out_valid, result, zero, illegal_op
    );

    modport slave (
        input  in_valid, alu_op, in1, in2,
        output out_valid, result, zero, illegal_op
    );
endinterface

// File: rtl/logic32_gate_bank.sv
// Purely combinational bank of bitwise gates feeding the logic unit's result mux.
// The XOR output exists only when LOGIC32_XOR_EN is defined.
module logic32_gate_bank #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] and_o,
    output logic [WIDTH-1:0] or_o,
`ifdef LOGIC32_XOR_EN
    output logic [WIDTH-1:0] xor_o,
`endif
    output logic [WIDTH-1:0] nor_o
);
    assign and_o = in1 & in2;
    assign or_o  = in1 | in2;
    assign nor_o = ~(in1 | in2);
`ifdef LOGIC32_XOR_EN
    assign xor_o = in1 ^ in2;
`endif
endmodule

// File: rtl/logic32_unit.sv
// Registered bitwise logic unit (AND/OR/NOR, optional XOR via LOGIC32_XOR_EN)
// with zero flag, illegal-opcode flag and a one-cycle valid strobe.
module logic32_unit
    import logic32_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic      clk,
    input logic      rst,
    logic32_if.slave bus
);
    logic [WIDTH-1:0] and_w;
    logic [WIDTH-1:0] or_w;
    logic [WIDTH-1:0] nor_w;
`ifdef LOGIC32_XOR_EN
    logic [WIDTH-1:0] xor_w;
`endif
    logic [WIDTH-1:0] op_res;

    logic             out_valid_d, out_valid_q;
    logic [WIDTH-1:0] result_d, result_q;
    logic             zero_d, zero_q;
    logic             illegal_op_d, illegal_op_q;

    logic32_gate_bank #(.WIDTH(WIDTH)) u_gates (
        .in1   (bus.in1),
        .in2   (bus.in2),
        .and_o (and_w),
        .or_o  (or_w),
`ifdef LOGIC32_XOR_EN
        .xor_o (xor_w),
`endif
        .nor_o (nor_w)
    );

    // Unselected and unsupported opcodes yield zero so operand X never reaches the result.
    always_comb begin
        op_res = '0;
        case (bus.alu_op)
            OP_AND32: op_res = and_w;
            OP_OR32:  op_res = or_w;
            OP_NOR32: op_res = nor_w;
`ifdef LOGIC32_XOR_EN
            OP_XOR32: op_res = xor_w;
`endif
            default:  op_res = '0;
        endcase
    end

    always_comb begin
        out_valid_d  = 1'b0;
        result_d     = result_q;
        zero_d       = zero_q;
        illegal_op_d = illegal_op_q;
        if (bus.in_valid) begin
            out_valid_d = 1'b1;
            if (is_logic_op(bus.alu_op)) begin
                result_d     = op_res;
                zero_d       = (op_res == '0);
                illegal_op_d = 1'b0;
            end else begin
                result_d     = '0;
                zero_d       = 1'b1;
                illegal_op_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            illegal_op_q <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
            illegal_op_q <= illegal_op_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.result     = result_q;
    assign bus.zero       = zero_q;
    assign bus.illegal_op = illegal_op_q;
endmodule

// File: tb/tb_logic32_unit.sv
// Scoreboard bench for logic32_unit: directed and random ops against a behavioural model.
// Expectations follow LOGIC32_XOR_EN when it is defined for the build.
module tb_logic32_unit;
    import logic32_pkg::*;

`ifdef LOGIC32_XOR_EN
    localparam bit XOR_EN = 1'b1;
`else
    localparam bit XOR_EN = 1'b0;
`endif

    typedef struct packed {
        logic        valid;
        logic [31:0] result;
        logic        zero;
        logic        illegal;
    } exp_t;

    logic clk;
    logic rst;
    logic32_if #(.WIDTH(32)) bus ();

    logic32_unit #(.WIDTH(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    int   vectors_applied = 0;
    int   miscompares = 0;

    logic [31:0] model_result = 32'h0;
    logic        model_zero = 1'b0;
    logic        model_illegal = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour: the architectural meaning of each opcode on whole words.
    function automatic exp_t model_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.valid   = 1'b1;
        e.illegal = 1'b0;
        if (op == 8'h02)                e.result = a & b;
        else if (op == 8'h03)           e.result = a | b;
        else if (op == 8'h05)           e.result = ~(a | b);
        else if (op == 8'h04 && XOR_EN) e.result = a ^ b;
        else begin
            e.result  = 32'h0;
            e.illegal = 1'b1;
        end
        e.zero = (e.result == 32'h0);
        return e;
    endfunction

    // Drives one cycle of inputs and queues what the outputs must show after the next edge.
    task automatic applyStimulus(input logic r, input logic v, input logic [7:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        rst          = r;
        bus.in_valid = v;
        bus.alu_op   = op;
        bus.in1      = a;
        bus.in2      = b;
        if (r) begin
            model_result  = 32'h0;
            model_zero    = 1'b0;
            model_illegal = 1'b0;
            e.valid       = 1'b0;
        end else if (v) begin
            e = model_op(op, a, b);
            model_result  = e.result;
            model_zero    = e.zero;
            model_illegal = e.illegal;
        end else begin
            e.valid = 1'b0;
        end
        e.result  = model_result;
        e.zero    = model_zero;
        e.illegal = model_illegal;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input exp_t e);
        vectors_applied++;
        if (bus.out_valid !== e.valid || bus.result !== e.result ||
            bus.zero !== e.zero || bus.illegal_op !== e.illegal) begin
            miscompares++;
            $display("[TB] FAIL vec%0d: got v=%b r=%h z=%b ill=%b, expected v=%b r=%h z=%b ill=%b",
                     vectors_applied, bus.out_valid, bus.result, bus.zero, bus.illegal_op,
                     e.valid, e.result, e.zero, e.illegal);
        end
    endtask

    // Monitor: every cycle's outputs are compared against the oldest queued expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            checkOutput(sb.pop_front());
        end else if (bus.out_valid === 1'b1) begin
            vectors_applied++;
            miscompares++;
            $display("[TB] FAIL unexpected_valid: got out_valid=1, expected no output");
        end
    end

    initial begin
        logic [7:0] op;
        logic [7:0] op_tab [6];
        op_tab = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h00, 8'h10};

        applyStimulus(1'b1, 1'b0, 8'h00, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 8'h00, 32'h0, 32'h0);

        applyStimulus(1'b0, 1'b1, OP_AND32, 32'h5, 32'h1);
        applyStimulus(1'b0, 1'b1, OP_OR32,  32'h5, 32'h1);
        applyStimulus(1'b0, 1'b1, OP_NOR32, 32'h5, 32'h1);

        applyStimulus(1'b0, 1'b1, OP_AND32, 32'hAAAAAAAA, 32'h55555555);
        applyStimulus(1'b0, 1'b1, OP_NOR32, 32'hAAAAAAAA, 32'h55555555);
        applyStimulus(1'b0, 1'b1, OP_OR32,  32'hAAAAAAAA, 32'h55555555);

        applyStimulus(1'b0, 1'b1, 8'h00, 32'h12345678, 32'h9ABCDEF0);
        applyStimulus(1'b0, 1'b1, 8'h10, 32'hFFFFFFFF, 32'h1);
        applyStimulus(1'b0, 1'b1, OP_XOR32, 32'h5, 32'h1);

        applyStimulus(1'b0, 1'b1, OP_OR32, 32'h00F0, 32'h0F00);
        applyStimulus(1'b0, 1'b0, OP_AND32, 32'h0, 32'h0);
        applyStimulus(1'b0, 1'b0, 8'h10, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b1, OP_NOR32, 32'h0, 32'h0);
        applyStimulus(1'b0, 1'b0, OP_OR32, 32'h1, 32'h1);

        for (int i = 0; i < 300; i++) begin
            int sel;
            sel = $urandom_range(0, 7);
            if (sel < 6)       op = op_tab[sel];
            else if (sel == 6) op = 8'($urandom);
            else               op = OP_NOR32;
            applyStimulus(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), op,
                          (($urandom_range(0, 7) == 0) ? 32'h0 : $urandom),
                          (($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom));
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 32'h0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end
endmodule
